// File: rtl/fib_index_finder.sv
// Fibonacci index finder: given a target, walks F(0), F(1), ... and reports
// the smallest index n with F(n) >= target, plus whether target is F(n).
//
// Ports:
//   clk           clock, all state updates on posedge
//   reset_button  asynchronous active-high reset
//   start         search request, sampled only while idle
//   target        value to locate, sampled with start
//   busy          high while a search or its done cycle is in progress
//   done          one-cycle pulse, result outputs valid
//   index         smallest n with F(n) >= target
//   fib_out       F(index), low WIDTH bits
//   is_fib        F(index) == target
//   overflow      F(index) does not fit in WIDTH bits
module fib_index_finder #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             reset_button,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] index,
   output logic [WIDTH-1:0] fib_out,
   output logic             is_fib,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SEARCH,
      S_DONE
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_tgt;
   // Two guard bits: the walk always reaches a >= tgt before a+b can wrap.
   logic [WIDTH+1:0]   r_a;
   logic [WIDTH+1:0]   r_b;
   logic [IDX_W-1:0]   r_n;
   logic               r_busy;
   logic               r_done;
   logic [IDX_W-1:0]   r_index;
   logic [WIDTH-1:0]   r_fib;
   logic               r_is_fib;
   logic               r_ovf;

   logic [WIDTH+1:0]   w_tgt_ext;
   logic [WIDTH+1:0]   w_sum;
   logic               w_hit;

   assign w_tgt_ext = {2'b00, r_tgt};
   assign w_sum     = r_a + r_b;
   assign w_hit     = (r_a >= w_tgt_ext);

   always_ff @(posedge clk or posedge reset_button) begin
      if (reset_button) begin
         r_state  <= S_IDLE;
         r_tgt    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_n      <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_index  <= '0;
         r_fib    <= '0;
         r_is_fib <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tgt   <= target;
                  r_a     <= '0;
                  r_b     <= {{(WIDTH+1){1'b0}}, 1'b1};
                  r_n     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               if (w_hit) begin
                  r_index  <= r_n;
                  r_fib    <= r_a[WIDTH-1:0];
                  r_is_fib <= (r_a == w_tgt_ext);
                  r_ovf    <= |r_a[WIDTH+1:WIDTH];
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_a <= r_b;
                  r_b <= w_sum;
                  r_n <= r_n + 1'b1;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign index    = r_index;
   assign fib_out  = r_fib;
   assign is_fib   = r_is_fib;
   assign overflow = r_ovf;

endmodule
